// File: rtl/pingpong_bram_if.sv
// pingpong_bram_if: bus bundle between the DMA-side writer / array-side reader
// and the double-buffered BRAM.
//   master modport: the agent driving writes, commits, reads and releases.
//   slave modport : the pingpong_bram itself.
// Write side : wea, wstrb, addra, dina, wr_commit -> wr_ready, wr_bank, wr_count
// Read side  : enb, addrb, rd_release -> rd_ready, rd_bank, doutb, doutb_valid
// Status     : err_wr, err_rd (sticky protocol errors)
interface pingpong_bram_if #(
  parameter int RAM_WIDTH  = 128,
  parameter int RAM_DEPTH  = 256,
  parameter int LANE_WIDTH = 8
);
  localparam int NLANE = RAM_WIDTH / LANE_WIDTH;
  localparam int AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int CW    = $clog2(RAM_DEPTH + 1);

  logic                 wea;
  logic [NLANE-1:0]     wstrb;
  logic [AW-1:0]        addra;
  logic [RAM_WIDTH-1:0] dina;
  logic                 wr_commit;
  logic                 wr_ready;
  logic                 wr_bank;
  logic [CW-1:0]        wr_count;

  logic                 enb;
  logic [AW-1:0]        addrb;
  logic                 rd_release;
  logic                 rd_ready;
  logic                 rd_bank;
  logic [RAM_WIDTH-1:0] doutb;
  logic                 doutb_valid;

  logic                 err_wr;
  logic                 err_rd;

  modport master (
    output wea, wstrb, addra, dina, wr_commit, enb, addrb, rd_release,
    input  wr_ready, wr_bank, wr_count, rd_ready, rd_bank, doutb, doutb_valid,
           err_wr, err_rd
  );

  modport slave (
    input  wea, wstrb, addra, dina, wr_commit, enb, addrb, rd_release,
    output wr_ready, wr_bank, wr_count, rd_ready, rd_bank, doutb, doutb_valid,
           err_wr, err_rd
  );
endinterface

// File: rtl/pingpong_bram.sv
// pingpong_bram: two-bank ping-pong simple dual-port RAM. The writer fills the
// bank selected by wr_sel while the reader drains the bank selected by rd_sel;
// a bank changes hands through wr_commit (writer -> reader) and rd_release
// (reader -> writer). Writes are lane-strobed, reads have a 1- or 2-cycle
// latency with a valid flag, and illegal handshakes raise sticky error flags.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : pingpong_bram_if.slave (write, read, handshake and status signals)
module pingpong_bram #(
  parameter int RAM_WIDTH  = 128,
  parameter int RAM_DEPTH  = 256,
  parameter int LANE_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  pingpong_bram_if.slave bus
);
  localparam int NLANE = RAM_WIDTH / LANE_WIDTH;
  localparam int CW    = $clog2(RAM_DEPTH + 1);

  logic [1:0]           full;
  logic [1:0]           full_next;
  logic                 wr_sel;
  logic                 rd_sel;
  logic [CW-1:0]        wr_count;
  logic                 err_wr;
  logic                 err_rd;
  logic                 wr_ready;
  logic                 rd_ready;
  logic                 wr_acc;
  logic                 cm_acc;
  logic                 rd_acc;
  logic                 rl_acc;
  logic [RAM_WIDTH-1:0] rd_q;
  logic                 rd_v;

  logic [RAM_WIDTH-1:0] mem [0:1][0:RAM_DEPTH-1];

  assign wr_ready = ~full[wr_sel];
  assign rd_ready = full[rd_sel];

  assign wr_acc = bus.wea        & wr_ready;
  assign cm_acc = bus.wr_commit  & wr_ready;
  assign rd_acc = bus.enb        & rd_ready;
  assign rl_acc = bus.rd_release & rd_ready;

  // Release is applied after commit so it wins on the same bank; that overlap
  // only happens when the commit is illegal anyway.
  always_comb begin
    full_next = full;
    if (cm_acc) full_next[wr_sel] = 1'b1;
    if (rl_acc) full_next[rd_sel] = 1'b0;
  end

  // A commit clears the count even if a write lands in the same cycle: that
  // write belongs to the bank being handed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 2'b00;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_count <= '0;
      err_wr   <= 1'b0;
      err_rd   <= 1'b0;
    end else begin
      full <= full_next;
      if (cm_acc) wr_sel <= ~wr_sel;
      if (rl_acc) rd_sel <= ~rd_sel;
      if (cm_acc)
        wr_count <= '0;
      else if (wr_acc && (wr_count != CW'(RAM_DEPTH)))
        wr_count <= wr_count + CW'(1);
      err_wr <= err_wr | ((bus.wea | bus.wr_commit) & ~wr_ready);
      err_rd <= err_rd | ((bus.enb | bus.rd_release) & ~rd_ready);
    end
  end

  // Storage has no reset so it maps onto block RAM; lanes with a cleared
  // strobe keep their previous contents.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      for (int i = 0; i < NLANE; i++) begin
        if (bus.wstrb[i])
          mem[wr_sel][bus.addra][i*LANE_WIDTH +: LANE_WIDTH] <=
            bus.dina[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // First read stage; data only changes on an accepted read so doutb holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= rd_acc;
      if (rd_acc) rd_q <= mem[rd_sel][bus.addrb];
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign bus.doutb       = rd_q;
      assign bus.doutb_valid = rd_v;
    end else begin : g_lat2
      logic [RAM_WIDTH-1:0] out_q;
      logic                 out_v;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else begin
          out_v <= rd_v;
          if (rd_v) out_q <= rd_q;
        end
      end

      assign bus.doutb       = out_q;
      assign bus.doutb_valid = out_v;
    end
  endgenerate

  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;
  assign bus.wr_bank  = wr_sel;
  assign bus.rd_bank  = rd_sel;
  assign bus.wr_count = wr_count;
  assign bus.err_wr   = err_wr;
  assign bus.err_rd   = err_rd;
endmodule

// File: tb/tb_pingpong_bram.sv
// tb_pingpong_bram: drives one stimulus stream into two pingpong_bram
// instances (RD_LATENCY 1 and 2) and checks them against a behavioural model.
// Expected reads are queued with their due cycle; a negedge monitor pops and
// compares whenever doutb_valid is seen, and flags missing or stray valids.
module tb_pingpong_bram;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int LW = 8;
  localparam int NL = W / LW;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] m;
    int           due;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  logic wea;
  logic [NL-1:0] wstrb;
  logic [AW-1:0] addra;
  logic [W-1:0]  dina;
  logic wr_commit;
  logic enb;
  logic [AW-1:0] addrb;
  logic rd_release;

  always #5 clk = ~clk;

  pingpong_bram_if #(.RAM_WIDTH(W), .RAM_DEPTH(D), .LANE_WIDTH(LW)) ia ();
  pingpong_bram_if #(.RAM_WIDTH(W), .RAM_DEPTH(D), .LANE_WIDTH(LW)) ib ();

  assign ia.wea = wea;       assign ib.wea = wea;
  assign ia.wstrb = wstrb;   assign ib.wstrb = wstrb;
  assign ia.addra = addra;   assign ib.addra = addra;
  assign ia.dina = dina;     assign ib.dina = dina;
  assign ia.wr_commit = wr_commit;   assign ib.wr_commit = wr_commit;
  assign ia.enb = enb;       assign ib.enb = enb;
  assign ia.addrb = addrb;   assign ib.addrb = addrb;
  assign ia.rd_release = rd_release; assign ib.rd_release = rd_release;

  pingpong_bram #(.RAM_WIDTH(W), .RAM_DEPTH(D), .LANE_WIDTH(LW), .RD_LATENCY(1))
    dut1 (.clk(clk), .rst(rst), .bus(ia));
  pingpong_bram #(.RAM_WIDTH(W), .RAM_DEPTH(D), .LANE_WIDTH(LW), .RD_LATENCY(2))
    dut2 (.clk(clk), .rst(rst), .bus(ib));

  logic [W-1:0] dout [2];
  logic         dv   [2];
  assign dout[0] = ia.doutb;  assign dv[0] = ia.doutb_valid;
  assign dout[1] = ib.doutb;  assign dv[1] = ib.doutb_valid;

  int nvec = 0;
  int nfail = 0;

  // Reference model state.
  bit [1:0]     m_full;
  bit           m_ws, m_rs, m_ew, m_er;
  int           m_cnt;
  logic [W-1:0] m_mem [2][D];
  logic [W-1:0] m_kn  [2][D];
  int           cyc = 0;
  rd_t          q [2][$];
  logic [W-1:0] last_d [2];
  logic [W-1:0] last_m [2];
  int           lat [2] = '{1, 2};

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < D; a++) begin
        m_mem[b][a] = '0;
        m_kn[b][a]  = '0;
      end
    for (int k = 0; k < 2; k++) begin
      last_d[k] = '0;
      last_m[k] = '0;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advances the model by one rising edge using the inputs currently driven.
  task automatic modelStep();
    bit       wr_ok, rd_ok;
    bit [1:0] nf;
    if (rst) begin
      m_full = 2'b00; m_ws = 0; m_rs = 0; m_cnt = 0; m_ew = 0; m_er = 0;
      for (int k = 0; k < 2; k++) begin
        q[k].delete();
        last_d[k] = '0;
        last_m[k] = '1;
      end
    end else begin
      wr_ok = !m_full[m_ws];
      rd_ok = m_full[m_rs];
      if (enb) begin
        if (rd_ok) begin
          for (int k = 0; k < 2; k++)
            q[k].push_back('{m_mem[m_rs][addrb], m_kn[m_rs][addrb], cyc + lat[k]});
        end else m_er = 1;
      end
      if (wea) begin
        if (wr_ok) begin
          for (int i = 0; i < NL; i++)
            if (wstrb[i]) begin
              m_mem[m_ws][addra][i*LW +: LW] = dina[i*LW +: LW];
              m_kn[m_ws][addra][i*LW +: LW]  = '1;
            end
          if (m_cnt < D) m_cnt++;
        end else m_ew = 1;
      end
      nf = m_full;
      if (wr_commit) begin
        if (wr_ok) begin
          nf[m_ws] = 1; m_ws = !m_ws; m_cnt = 0;
        end else m_ew = 1;
      end
      if (rd_release) begin
        if (rd_ok) begin
          nf[m_rs] = 0; m_rs = !m_rs;
        end else m_er = 1;
      end
      m_full = nf;
    end
    cyc++;
  endtask

  task automatic checkDut(input string t, input logic wrdy, input logic rrdy,
                          input logic wb, input logic rb, input logic [CW-1:0] cnt,
                          input logic ew, input logic er);
    cmp({t, "_wr_ready"}, wrdy, !m_full[m_ws]);
    cmp({t, "_rd_ready"}, rrdy, m_full[m_rs]);
    cmp({t, "_wr_bank"}, wb, m_ws);
    cmp({t, "_rd_bank"}, rb, m_rs);
    cmp({t, "_wr_count"}, cnt, m_cnt);
    cmp({t, "_err_wr"}, ew, m_ew);
    cmp({t, "_err_rd"}, er, m_er);
  endtask

  task automatic checkOutput();
    checkDut("L1", ia.wr_ready, ia.rd_ready, ia.wr_bank, ia.rd_bank, ia.wr_count, ia.err_wr, ia.err_rd);
    checkDut("L2", ib.wr_ready, ib.rd_ready, ib.wr_bank, ib.rd_bank, ib.wr_count, ib.err_wr, ib.err_rd);
  endtask

  task automatic applyStimulus(input bit r, input bit we, input logic [NL-1:0] st,
                               input logic [AW-1:0] aa, input logic [W-1:0] d,
                               input bit cm, input bit en, input logic [AW-1:0] ab,
                               input bit rl);
    rst = r; wea = we; wstrb = st; addra = aa; dina = d;
    wr_commit = cm; enb = en; addrb = ab; rd_release = rl;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, 0);
  endtask
  task automatic doReset();
    applyStimulus(1, 0, '0, '0, '0, 0, 0, '0, 0);
  endtask
  task automatic doWrite(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NL-1:0] st);
    applyStimulus(0, 1, st, a, d, 0, 0, '0, 0);
  endtask
  task automatic doRead(input logic [AW-1:0] a);
    applyStimulus(0, 0, '0, '0, '0, 0, 1, a, 0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic string tag = (k == 0) ? "L1" : "L2";
      automatic rd_t e;
      if (dv[k] === 1'b1) begin
        if (q[k].size() == 0) begin
          cmp({tag, "_unexpected_valid"}, 1, 0);
        end else begin
          e = q[k].pop_front();
          cmp({tag, "_rd_latency"}, cyc, e.due);
          cmp({tag, "_rd_data"}, dout[k] & e.m, e.d & e.m);
          last_d[k] = e.d;
          last_m[k] = e.m;
        end
      end else begin
        if (q[k].size() > 0 && q[k][0].due <= cyc) begin
          cmp({tag, "_missing_valid"}, 0, 1);
          void'(q[k].pop_front());
        end
        if (last_m[k] != '0)
          cmp({tag, "_dout_hold"}, dout[k] & last_m[k], last_d[k] & last_m[k]);
      end
    end
  end

  initial begin
    rst = 1; wea = 0; wstrb = '0; addra = '0; dina = '0;
    wr_commit = 0; enb = 0; addrb = '0; rd_release = 0;

    doReset(); doReset();
    cmp("rst_doutb_L2", ib.doutb, 0);

    // Basic fill, commit and read-back at both latencies.
    doWrite(0, 32'h11, '1); doWrite(1, 32'h22, '1);
    doWrite(2, 32'h33, '1); doWrite(3, 32'h44, '1);
    cmp("t1_count4", ia.wr_count, 4);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 0);
    cmp("t1_wr_bank", ia.wr_bank, 1);
    cmp("t1_rd_ready", ib.rd_ready, 1);
    cmp("t1_count0", ib.wr_count, 0);
    for (int a = 0; a < 4; a++) doRead(AW'(a));
    idle(3);

    // Lane strobe into bank 1, then commit with both banks full.
    doWrite(5, '1, '1);
    doWrite(5, '0, 4'b0001);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 0);
    cmp("t2_wr_ready0", ia.wr_ready, 0);
    // Illegal write while both banks are full must leave memory intact.
    doWrite(5, 32'h0, '1);
    cmp("t4_err_wr", ia.err_wr, 1);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, 1);
    cmp("t3_rd_bank1", ia.rd_bank, 1);
    // Read bank 1 while refilling bank 0.
    for (int a = 0; a < 4; a++)
      applyStimulus(0, 1, '1, AW'(a), 32'hA0 + a, 0, 1, 5, 0);
    idle(2);
    // Commit and release in one cycle on different banks.
    applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 1);
    cmp("t5_rd_bank0", ib.rd_bank, 0);
    cmp("t5_wr_bank1", ib.wr_bank, 1);
    cmp("t5_err_rd", ib.err_rd, 0);
    for (int a = 0; a < 4; a++) doRead(AW'(a));
    idle(3);
    cmp("t4_err_wr_sticky", ib.err_wr, 1);

    // Read with nothing committed, then reset over an in-flight read.
    doReset();
    doRead(0);
    cmp("t6_err_rd", ia.err_rd, 1);
    doWrite(0, 32'hCAFE, '1);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 0);
    doRead(0);
    doReset();
    cmp("t6_valid_after_rst", ib.doutb_valid, 0);
    idle(3);

    // Count saturation.
    for (int i = 0; i < D + 3; i++) doWrite(AW'(i), $urandom, '1);
    cmp("sat_count", ia.wr_count, D);

    // Randomised traffic, mostly following the handshake rules.
    doReset();
    for (int i = 0; i < 800; i++) begin
      automatic bit r  = ($urandom_range(0, 199) == 0);
      automatic bit we = ($urandom_range(0, 1) == 1) && (!m_full[m_ws] || $urandom_range(0, 19) == 0);
      automatic bit cm = ($urandom_range(0, 11) == 0) && (!m_full[m_ws] || $urandom_range(0, 9) == 0);
      automatic bit en = ($urandom_range(0, 1) == 1) && (m_full[m_rs] || $urandom_range(0, 19) == 0);
      automatic bit rl = ($urandom_range(0, 11) == 0) && (m_full[m_rs] || $urandom_range(0, 9) == 0);
      applyStimulus(r, we, NL'($urandom), AW'($urandom), $urandom, cm, en, AW'($urandom), rl);
    end
    idle(4);
    cmp("L1_queue_drained", q[0].size(), 0);
    cmp("L2_queue_drained", q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
